pulse_rx: RTL and testbench
===========================

# pulse_rx

Receive-side companion to the testbench stimulus drivers: samples an asynchronous single-bit line (such as a delayed/annotated DUT output), synchronizes it, and measures the width of every stable level segment in clock cycles. Each completed segment is presented as one record on a valid/ready interface, so benches and on-chip checkers can verify pulse timing after interconnect/SDF delays without event-driven monitors.

## Interface
- `SYNC_STAGES`, 2, synchronizer flop count (>=2)
- `CNT_W`, 16, width counter/record width (>=2)
- `MIN_WIDTH`, 2, glitch threshold in cycles (used only with filter macro)

- `clk` input 1 sole clock, rising edge
- `rst_n` input 1 asynchronous active-low reset
- `in` input 1 asynchronous monitored line
- `en` input 1 measurement enable
- `meas_valid` output 1 record available
- `meas_ready` input 1 consumer accepts record
- `meas_width` output CNT_W segment length in cycles
- `meas_level` output 1 level of the measured segment
- `meas_ovf` output 1 width saturated
- `drop` output 1 sticky: record lost to full buffer
- `busy` output 1 FSM in COUNT

One clock; reset is asynchronous and active-low.

## Operation
- Sync chain of SYNC_STAGES flops resets to 0; `sq` = last stage, `prev` = `sq` delayed one cycle (resets 0). Edge = `sq != prev`.
- FSM states:
  - IDLE: counter cleared. `en`=1 -> ARMED.
  - ARMED: wait for first edge (prior segment length unknown, no record). Edge -> COUNT, counter=1.
  - COUNT: each non-edge cycle counter+1, saturating at 2^CNT_W-1. On edge: emit record {width=counter, level=`prev`, ovf=(counter==max)}, counter=1, stay in COUNT.
  - `en`=0 in any state -> IDLE next cycle; partial segment discarded; buffered record kept.
- Output: one-entry buffer. Record loads when buffer empty, or when `meas_valid && meas_ready` in the same cycle as emit (no drop). Emit while buffer full and not being popped -> new record discarded, `drop` set.
- `meas_width/level/ovf` stable while `meas_valid`=1 and not accepted.
- `drop` cleared while `en`=0.
- `busy`=1 exactly in COUNT.

## Timing
- Reset values: `meas_valid`=0, `meas_width`=0, `meas_level`=0, `meas_ovf`=0, `drop`=0, `busy`=0, FSM=IDLE.
- Reset mid-operation clears everything immediately (async); no record survives.
- `in` change sampled at edge k -> `sq` changes at edge k+SYNC_STAGES-1 -> edge-detect cycle -> `meas_valid` high after following edge (record latency SYNC_STAGES+1 cycles from sampling).
- Width of a level held N sampled cycles = N (edge-to-edge).
- Accept on `meas_valid && meas_ready` at rising edge; `meas_valid` drops next cycle unless refilled same cycle.
- `meas_valid` must not depend combinationally on `meas_ready`.
- Consecutive edges every cycle: width=1 records each cycle; sustained only with `meas_ready`=1.

## Configuration
- `PULSE_RX_GLITCH_FILTER_EN` defined: a completed segment with width < MIN_WIDTH emits no record and does not set `drop`; counter restarts at 1 as normal. Not defined: every segment emits a record, MIN_WIDTH ignored.

## Test plan
- Reset, `en`=1, `in` 0->1 at cycle 10, 1->0 at cycle 15, 0->1 at 25 -> records {5, level 1}, {10, level 0}; first edge yields no record.
- Latency: SYNC_STAGES=3, single edge pair -> `meas_valid` rises 4 cycles after the sampling edge of the second transition.
- CNT_W=4, level held 40 cycles -> width=15, `meas_ovf`=1.
- `meas_ready`=0, three segments complete -> first record held unchanged, `drop`=1; ready=1 with simultaneous emit -> new record loaded, no drop; `en`=0 clears `drop`.
- `en` dropped mid-segment, then re-raised -> no record for partial segment, ARMED again; `rst_n` low mid-COUNT -> all outputs 0 immediately.
- With `PULSE_RX_GLITCH_FILTER_EN`, MIN_WIDTH=3: 1-cycle pulse suppressed, 3-cycle pulse reported; without macro both reported.

Source files
------------

// File: rtl/pulse_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_rx : synchronizes an asynchronous line and reports the width and      |
// |            level of every stable segment on a one-entry valid/ready buffer. |
// | Optional : PULSE_RX_GLITCH_FILTER_EN suppresses segments below MIN_WIDTH.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pulse_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int MIN_WIDTH   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             en,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] meas_width,
   output logic             meas_level,
   output logic             meas_ovf,
   output logic             drop,
   output logic             busy
);

   localparam logic [1:0]       c_st_idle  = 2'd0;
   localparam logic [1:0]       c_st_armed = 2'd1;
   localparam logic [1:0]       c_st_count = 2'd2;
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

   if (SYNC_STAGES < 2 || CNT_W < 2 || MIN_WIDTH < 1) begin : g_param_check
      $error("pulse_rx: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_edge;
   logic                   r_lvl;
   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_keep;
   logic                   w_emit;
   logic                   w_pop;

   // Edge and pre-edge level are registered so the record is built from flops only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_edge <= 1'b0;
         r_lvl  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_edge <= r_sync[SYNC_STAGES-1] ^ r_prev;
         r_lvl  <= r_prev;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_st_idle;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!en) begin
         w_state_nxt = c_st_idle;
      end else begin
         case (r_state)
            c_st_idle:  w_state_nxt = c_st_armed;
            c_st_armed: if (r_edge) w_state_nxt = c_st_count;
            c_st_count: w_state_nxt = c_st_count;
            default:    w_state_nxt = c_st_idle;
         endcase
      end
   end

`ifdef PULSE_RX_GLITCH_FILTER_EN
   localparam logic [CNT_W-1:0] c_min_w = CNT_W'(MIN_WIDTH);
   assign w_keep = (r_cnt >= c_min_w);
`else
   assign w_keep = 1'b1;
`endif

   always_comb begin
      busy   = (r_state == c_st_count);
      w_emit = busy && en && r_edge && w_keep;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!en || r_state == c_st_idle) begin
         r_cnt <= '0;
      end else if (r_edge) begin
         r_cnt <= c_cnt_one;
      end else if (r_state == c_st_count && r_cnt != c_cnt_max) begin
         r_cnt <= r_cnt + c_cnt_one;
      end
   end

   assign w_pop = meas_valid && meas_ready;

   // A pop in the emit cycle frees the slot, so the new record is not dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_valid <= 1'b0;
         meas_width <= '0;
         meas_level <= 1'b0;
         meas_ovf   <= 1'b0;
         drop       <= 1'b0;
      end else begin
         if (w_emit && (!meas_valid || w_pop)) begin
            meas_valid <= 1'b1;
            meas_width <= r_cnt;
            meas_level <= r_lvl;
            meas_ovf   <= (r_cnt == c_cnt_max);
         end else if (w_pop) begin
            meas_valid <= 1'b0;
         end

         if (!en)                              drop <= 1'b0;
         else if (w_emit && meas_valid && !w_pop) drop <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pulse_rx.sv
`default_nettype none
// Bench for pulse_rx: scoreboard of expected segment records built from the driven
// waveform, plus scenario tasks for latency, overflow, backpressure, enable and reset.
module tb_pulse_rx;

   localparam int SYNC_STAGES = 3;
   localparam int CNT_W       = 4;
   localparam int MIN_WIDTH   = 3;
   localparam int MAXW        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in;
   logic             en;
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_width;
   logic             meas_level;
   logic             meas_ovf;
   logic             drop;
   logic             busy;

   typedef struct packed {
      logic [CNT_W-1:0] width;
      logic             level;
      logic             ovf;
   } rec_t;

   rec_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic have_first = 1'b0;
   int   cur_len = 0;
   logic push_en = 1'b1;

   pulse_rx #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .MIN_WIDTH  (MIN_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .en        (en),
      .meas_valid(meas_valid),
      .meas_ready(meas_ready),
      .meas_width(meas_width),
      .meas_level(meas_level),
      .meas_ovf  (meas_ovf),
      .drop      (drop),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   // One cycle; any record accepted this cycle is popped against the scoreboard.
   task automatic tick();
      rec_t exp;
      @(negedge clk);
      if (rst_n && meas_valid && meas_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got width=%0d level=%0d ovf=%0d, required no record",
                     meas_width, meas_level, meas_ovf);
         end else begin
            exp = sb.pop_front();
            if ({meas_width, meas_level, meas_ovf} !== exp) begin
               errors++;
               $display("FAIL sb_record: got width=%0d level=%0d ovf=%0d, required width=%0d level=%0d ovf=%0d",
                        meas_width, meas_level, meas_ovf, exp.width, exp.level, exp.ovf);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Drive a level for n cycles; a level change closes the running segment.
   task automatic seg(input logic lvl, input int n);
      rec_t r;
      if (lvl !== in) begin
         if (have_first && push_en) begin
            r.width = CNT_W'((cur_len > MAXW) ? MAXW : cur_len);
            r.level = in;
            r.ovf   = (cur_len >= MAXW);
`ifdef PULSE_RX_GLITCH_FILTER_EN
            if (cur_len >= MIN_WIDTH)
`endif
               sb.push_back(r);
         end
         have_first = 1'b1;
         cur_len    = 0;
      end
      in = lvl;
      repeat (n) begin
         tick();
         cur_len++;
      end
   endtask

   task automatic rearm();
      en = 1'b0;
      repeat (2) tick();
      have_first = 1'b0;
      cur_len    = 0;
      en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in = 1'b0; en = 1'b0; meas_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if ({meas_valid, meas_width, meas_level, meas_ovf, drop, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0d width=%0d level=%0d ovf=%0d drop=%0d busy=%0d, required all 0",
                  meas_valid, meas_width, meas_level, meas_ovf, drop, busy);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (meas_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got valid=%0d busy=%0d, required 0 0", meas_valid, busy);
      end
   endtask

   task automatic test_basic();
      meas_ready = 1'b1;
      en = 1'b1;
      seg(1'b0, 10);
      seg(1'b1, 5);
      seg(1'b0, 10);
      seg(1'b1, 8);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL basic_drain: got %0d records outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_latency();
      logic l;
      int   lat;
      meas_ready = 1'b0;
      rearm();
      l = ~in;
      seg(l, 6);
      seg(~l, 0);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (meas_valid) begin
            lat = i - 1;
            break;
         end
      end
      checks++;
      if (lat !== SYNC_STAGES + 1) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required %0d", lat, SYNC_STAGES + 1);
      end
      meas_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_overflow();
      meas_ready = 1'b1;
      rearm();
      seg(1'b1, 3);
      seg(1'b0, 40);
      seg(1'b1, 8);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL ovf_drain: got %0d records outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_backpressure();
      logic l, l2;
      meas_ready = 1'b0;
      rearm();
      l = ~in;
      seg(l, 5);
      seg(~l, 6);
      push_en = 1'b0;
      seg(l, 7);
      seg(~l, 8);
      push_en = 1'b1;
      checks++;
      if (meas_valid !== 1'b1 || meas_width !== CNT_W'(5) || meas_level !== l || drop !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: got valid=%0d width=%0d level=%0d drop=%0d, required 1 5 %0d 1",
                  meas_valid, meas_width, meas_level, drop, l);
      end
      rearm();
      checks++;
      if (drop !== 1'b0 || meas_valid !== 1'b1 || meas_width !== CNT_W'(5)) begin
         errors++;
         $display("FAIL bp_en_clear: got drop=%0d valid=%0d width=%0d, required 0 1 5",
                  drop, meas_valid, meas_width);
      end
      l2 = ~in;
      seg(l2, 6);
      seg(~l2, 4);
      meas_ready = 1'b1;
      tick();
      meas_ready = 1'b0;
      checks++;
      if (meas_valid !== 1'b1 || meas_width !== CNT_W'(6) || meas_level !== l2 || drop !== 1'b0) begin
         errors++;
         $display("FAIL bp_refill: got valid=%0d width=%0d level=%0d drop=%0d, required 1 6 %0d 0",
                  meas_valid, meas_width, meas_level, drop, l2);
      end
      meas_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got %0d records outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_enable_drop();
      logic l;
      meas_ready = 1'b1;
      rearm();
      l = ~in;
      seg(l, 4);
      seg(~l, 8);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL en_busy_count: got busy=%0d, required 1", busy);
      end
      en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL en_busy_idle: got busy=%0d, required 0", busy);
      end
      tick();
      have_first = 1'b0;
      cur_len    = 0;
      en = 1'b1;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL en_busy_armed: got busy=%0d, required 0", busy);
      end
      seg(l, 5);
      seg(~l, 7);
      seg(l, 6);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL en_drain: got %0d records outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_glitch();
      logic l;
      meas_ready = 1'b1;
      rearm();
      l = ~in;
      seg(l, 5);
      seg(~l, 1);
      seg(l, 3);
      seg(~l, 5);
      seg(l, 8);
      checks++;
      if (sb.size() != 0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL glitch_drain: got %0d outstanding drop=%0d, required 0 0", sb.size(), drop);
      end
   endtask

   task automatic test_back_to_back();
      logic l;
      meas_ready = 1'b1;
      rearm();
      l = ~in;
      seg(l, 3);
      for (int i = 0; i < 6; i++) seg(~in, 1);
      seg(~in, 8);
      checks++;
      if (sb.size() != 0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d outstanding drop=%0d, required 0 0", sb.size(), drop);
      end
   endtask

   task automatic test_async_reset();
      logic l;
      meas_ready = 1'b0;
      rearm();
      push_en = 1'b0;
      l = ~in;
      seg(l, 4);
      seg(~l, 4);
      seg(l, 4);
      seg(~l, 8);
      checks++;
      if (busy !== 1'b1 || meas_valid !== 1'b1 || drop !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup: got busy=%0d valid=%0d drop=%0d, required 1 1 1", busy, meas_valid, drop);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({meas_valid, meas_width, meas_level, meas_ovf, drop, busy} !== '0) begin
         errors++;
         $display("FAIL rst_async: got valid=%0d width=%0d level=%0d ovf=%0d drop=%0d busy=%0d, required all 0",
                  meas_valid, meas_width, meas_level, meas_ovf, drop, busy);
      end
      sb.delete();
      in = 1'b0;
      push_en = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in = 1'b0; en = 1'b0; meas_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_latency();
      test_overflow();
      test_backpressure();
      test_enable_drop();
      test_glitch();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
